// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue sequencer and its divider.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DIV, DONE} state_t;

  localparam logic [1:0] OPC_DIV        = 2'd2;
  localparam logic [3:0] OP3_UDIV       = 4'he;
  localparam logic [3:0] OP3_SDIV       = 4'hf;
  localparam int         DIV_CYCLES_DEF = 32;

  function automatic logic is_div_op(input logic [1:0] opcode, input logic [3:0] op3_low);
    return (opcode == OPC_DIV) && ((op3_low == OP3_UDIV) || (op3_low == OP3_SDIV));
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle on magnitudes,
// with the signs re-applied to quotient and remainder on the way out.
module div_iter
  import alu_pkg::*;
#(
  parameter int CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;
  logic [31:0]   rem_q;
  logic [31:0]   quo_q;
  logic [31:0]   dsr_q;
  logic          quo_neg_q;
  logic          rem_neg_q;
  logic [31:0]   abs_dvd;
  logic [31:0]   abs_dsr;
  logic [32:0]   shifted;
  logic [32:0]   diff;

  always_comb begin
    abs_dvd = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    abs_dsr = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dsr_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count     <= CW'(CYCLES);
      rem_q     <= '0;
      quo_q     <= abs_dvd;
      dsr_q     <= abs_dsr;
      quo_neg_q <= is_signed && (dividend[31] ^ divisor[31]);
      rem_neg_q <= is_signed && dividend[31];
    end else if (count != '0) begin
      count <= count - CW'(1);
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  // done flags the cycle whose closing edge performs the final iteration
  assign done      = (count == CW'(1));
  assign quotient  = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
  assign remainder = rem_neg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/alu_seq.sv
// Issue sequencer: forwards ALU ops with a one-cycle enable and runs divides
// on the iterative divider, merging both result paths toward the memory stage.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [1:0]      iss_opcode,
  input  logic [2:0]      iss_op2,
  input  logic [5:0]      iss_op3,
  input  logic [31:0]     iss_oprd2,
  input  logic [31:0]     iss_oprd3,
  input  logic            flush,
  input  logic            mem_blocked,
  output logic            alu_enable,
  output logic [1:0]      alu_opcode,
  output logic [2:0]      alu_op2,
  output logic [5:0]      alu_op3,
  output logic [31:0]     alu_oprd2,
  output logic [31:0]     alu_oprd3,
  input  logic [63:0]     alu_result,
  input  logic            alu_exe_mem,
  output logic            exe_valid,
  output logic [XLEN-1:0] exe_result,
  output logic            exe_div_zero,
  output logic            busy
);

  state_t      state;
  logic        accept;
  logic        is_div;
  logic        div_start;
  logic        div_done;
  logic        div_zero_q;
  logic        div_signed_q;
  logic        alu_pend;
  logic        done_out;
  logic [31:0] div_quo;
  logic [31:0] unused_rem;

  // reset_n gates ready so it stays low while reset is held, despite IDLE
  assign iss_ready = reset_n && (state == IDLE) && !mem_blocked && !flush;
  assign accept    = iss_valid && iss_ready;
  assign is_div    = is_div_op(iss_opcode, iss_op3[3:0]);
  assign div_start = accept && is_div && (iss_oprd3 != '0);

  div_iter #(.CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .clear     (flush),
    .dividend  (iss_oprd2),
    .divisor   (iss_oprd3),
    .is_signed (iss_op3[3:0] == OP3_SDIV),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (unused_rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      alu_enable   <= 1'b0;
      alu_opcode   <= '0;
      alu_op2      <= '0;
      alu_op3      <= '0;
      alu_oprd2    <= '0;
      alu_oprd3    <= '0;
      div_zero_q   <= 1'b0;
      div_signed_q <= 1'b0;
      alu_pend     <= 1'b0;
    end else begin
      alu_enable <= 1'b0;
      alu_pend   <= (state == ISSUE) && !flush;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_div) begin
              div_signed_q <= (iss_op3[3:0] == OP3_SDIV);
              div_zero_q   <= (iss_oprd3 == '0);
              state        <= (iss_oprd3 == '0) ? DONE : DIV;
            end else begin
              alu_opcode <= iss_opcode;
              alu_op2    <= iss_op2;
              alu_op3    <= iss_op3;
              alu_oprd2  <= iss_oprd2;
              alu_oprd3  <= iss_oprd3;
              alu_enable <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: state <= IDLE;
        DIV: begin
          if (flush)         state <= IDLE;
          else if (div_done) state <= DONE;
        end
        DONE: begin
          if (flush || !mem_blocked) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flushed DONE cycle must not present its result as valid
  assign done_out     = (state == DONE) && !flush;
  assign exe_valid    = done_out || (alu_pend && alu_exe_mem);
  assign exe_div_zero = done_out && div_zero_q;
  assign busy         = (state != IDLE);

  always_comb begin
    exe_result = '0;
    if (state == DONE) begin
      if (div_zero_q) exe_result = '1;
      else            exe_result = {{(XLEN-32){div_signed_q & div_quo[31]}}, div_quo};
    end else if (alu_pend) begin
      exe_result = alu_result[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a simple registered adder standing in for the ALU.
module tb_alu_seq;

  localparam int DIV_CYCLES = 32;
  localparam int XLEN       = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            iss_valid;
  logic            iss_ready;
  logic [1:0]      iss_opcode;
  logic [2:0]      iss_op2;
  logic [5:0]      iss_op3;
  logic [31:0]     iss_oprd2;
  logic [31:0]     iss_oprd3;
  logic            flush;
  logic            mem_blocked;
  logic            alu_enable;
  logic [1:0]      alu_opcode;
  logic [2:0]      alu_op2;
  logic [5:0]      alu_op3;
  logic [31:0]     alu_oprd2;
  logic [31:0]     alu_oprd3;
  logic [63:0]     alu_result;
  logic            alu_exe_mem;
  logic            exe_valid;
  logic [XLEN-1:0] exe_result;
  logic            exe_div_zero;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  alu_seq #(.DIV_CYCLES(DIV_CYCLES), .XLEN(XLEN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_opcode   (iss_opcode),
    .iss_op2      (iss_op2),
    .iss_op3      (iss_op3),
    .iss_oprd2    (iss_oprd2),
    .iss_oprd3    (iss_oprd3),
    .flush        (flush),
    .mem_blocked  (mem_blocked),
    .alu_enable   (alu_enable),
    .alu_opcode   (alu_opcode),
    .alu_op2      (alu_op2),
    .alu_op3      (alu_op3),
    .alu_oprd2    (alu_oprd2),
    .alu_oprd3    (alu_oprd3),
    .alu_result   (alu_result),
    .alu_exe_mem  (alu_exe_mem),
    .exe_valid    (exe_valid),
    .exe_result   (exe_result),
    .exe_div_zero (exe_div_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: registers the sum one cycle after its enable pulse
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_exe_mem <= 1'b0;
      alu_result  <= '0;
    end else begin
      alu_exe_mem <= alu_enable;
      if (alu_enable) alu_result <= {32'd0, alu_oprd2} + {32'd0, alu_oprd3};
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] opcode, input logic [2:0] op2, input logic [5:0] op3,
                               input logic [31:0] a, input logic [31:0] b);
    iss_valid  = 1'b1;
    iss_opcode = opcode;
    iss_op2    = op2;
    iss_op3    = op3;
    iss_oprd2  = a;
    iss_oprd3  = b;
  endtask

  task automatic run_alu(input string tag, input logic [1:0] opcode, input logic [5:0] op3,
                         input logic [31:0] a, input logic [31:0] b, input logic flush_c1);
    @(posedge clk); #1;
    applyStimulus(opcode, 3'd1, op3, a, b);
    @(negedge clk);
    checkOutput({tag, " ready c0"}, iss_ready, 1);
    @(posedge clk); #1;
    iss_valid = 1'b0;
    flush     = flush_c1;
    @(negedge clk);
    checkOutput({tag, " enable c1"}, alu_enable, 1);
    checkOutput({tag, " busy c1"}, busy, 1);
    checkOutput({tag, " ready c1"}, iss_ready, 0);
    checkOutput({tag, " oprd2 c1"}, alu_oprd2, a);
    checkOutput({tag, " oprd3 c1"}, alu_oprd3, b);
    checkOutput({tag, " opcode c1"}, alu_opcode, opcode);
    checkOutput({tag, " op3 c1"}, alu_op3, op3);
    checkOutput({tag, " valid c1"}, exe_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput({tag, " enable c2"}, alu_enable, 0);
    checkOutput({tag, " busy c2"}, busy, 0);
    checkOutput({tag, " valid c2"}, exe_valid, !flush_c1);
    if (!flush_c1) begin
      checkOutput({tag, " result c2"}, exe_result, {32'd0, a} + {32'd0, b});
      checkOutput({tag, " divzero c2"}, exe_div_zero, 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, " valid c3"}, exe_valid, 0);
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expected, input int blk_lo, input int blk_hi);
    int ds;
    int de;
    logic vld;
    ds = (b == 32'd0) ? 1 : DIV_CYCLES + 1;
    de = ds;
    while (de >= blk_lo && de <= blk_hi) de++;
    @(posedge clk); #1;
    applyStimulus(2'd2, 3'd0, sgn ? 6'h0F : 6'h2E, a, b);
    mem_blocked = 1'b0;
    @(negedge clk);
    checkOutput({tag, " ready c0"}, iss_ready, 1);
    for (int c = 1; c <= de + 1; c++) begin
      @(posedge clk); #1;
      iss_valid   = 1'b0;
      mem_blocked = (c >= blk_lo && c <= blk_hi);
      @(negedge clk);
      vld = (c >= ds && c <= de);
      checkOutput($sformatf("%s busy c%0d", tag, c), busy, (c <= de));
      checkOutput($sformatf("%s valid c%0d", tag, c), exe_valid, vld);
      checkOutput($sformatf("%s ready c%0d", tag, c), iss_ready, (c > de) && !mem_blocked);
      checkOutput($sformatf("%s enable c%0d", tag, c), alu_enable, 0);
      checkOutput($sformatf("%s divzero c%0d", tag, c), exe_div_zero, vld && (b == 32'd0));
      if (vld) checkOutput($sformatf("%s result c%0d", tag, c), exe_result, expected);
    end
    mem_blocked = 1'b0;
  endtask

  task automatic blocked_issue(input string tag, input logic mb, input logic fl);
    @(posedge clk); #1;
    applyStimulus(2'd0, 3'd0, 6'h00, 32'd1, 32'd2);
    mem_blocked = mb;
    flush       = fl;
    @(negedge clk);
    checkOutput({tag, " ready c0"}, iss_ready, 0);
    @(posedge clk); #1;
    iss_valid   = 1'b0;
    mem_blocked = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    checkOutput({tag, " busy c1"}, busy, 0);
    checkOutput({tag, " enable c1"}, alu_enable, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    iss_valid   = 1'b0;
    iss_opcode  = '0;
    iss_op2     = '0;
    iss_op3     = '0;
    iss_oprd2   = '0;
    iss_oprd3   = '0;
    flush       = 1'b0;
    mem_blocked = 1'b0;

    @(negedge clk);
    checkOutput("rst ready", iss_ready, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst valid", exe_valid, 0);
    checkOutput("rst result", exe_result, 0);
    checkOutput("rst enable", alu_enable, 0);
    checkOutput("rst divzero", exe_div_zero, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post rst ready", iss_ready, 1);
    checkOutput("post rst busy", busy, 0);

    run_alu("add", 2'd0, 6'h05, 32'd5, 32'd7, 1'b0);
    run_alu("add_carry", 2'd1, 6'h01, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_alu("op3_d", 2'd2, 6'h0D, 32'd20, 32'd22, 1'b0);
    run_alu("alu_flush", 2'd1, 6'h00, 32'd3, 32'd4, 1'b1);

    run_div("udiv", 1'b0, 32'd100, 32'd7, 64'd14, 1, 0);
    run_div("sdiv_neg", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1, 0);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0);
    run_div("udiv_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1, 0);
    run_div("udiv_big", 1'b0, 32'hFFFF_FF9C, 32'd7, 64'h0000_0000_2492_4916, 1, 0);
    run_div("sdiv_zero", 1'b1, 32'hFFFF_FF9C, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_div("udiv_blk", 1'b0, 32'd100, 32'd7, 64'd14, 20, 40);
    run_div("zero_blk", 1'b0, 32'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3);

    blocked_issue("issue_mb", 1'b1, 1'b0);
    blocked_issue("issue_flush", 1'b0, 1'b1);

    // Divide flushed in cycle 10, then a normal ALU op
    @(posedge clk); #1;
    applyStimulus(2'd2, 3'd0, 6'h0E, 32'd100, 32'd7);
    @(negedge clk);
    checkOutput("flush ready c0", iss_ready, 1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      iss_valid = 1'b0;
      flush     = (c == 10);
      @(negedge clk);
      checkOutput($sformatf("flush busy c%0d", c), busy, (c <= 10));
      checkOutput($sformatf("flush valid c%0d", c), exe_valid, 0);
      checkOutput($sformatf("flush ready c%0d", c), iss_ready, (c >= 11));
    end
    flush = 1'b0;
    run_alu("after_flush", 2'd0, 6'h05, 32'd9, 32'd30, 1'b0);

    // Reset asserted in cycle 15 of a divide, released in cycle 17
    @(posedge clk); #1;
    applyStimulus(2'd2, 3'd0, 6'h0E, 32'd1000, 32'd3);
    @(negedge clk);
    checkOutput("rstdiv ready c0", iss_ready, 1);
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      iss_valid = 1'b0;
      if (c == 15) reset_n = 1'b0;
      if (c == 17) reset_n = 1'b1;
      @(negedge clk);
      if (c < 15) begin
        checkOutput($sformatf("rstdiv busy c%0d", c), busy, 1);
      end else if (c <= 16) begin
        checkOutput($sformatf("rstdiv busy c%0d", c), busy, 0);
        checkOutput($sformatf("rstdiv ready c%0d", c), iss_ready, 0);
        checkOutput($sformatf("rstdiv valid c%0d", c), exe_valid, 0);
        checkOutput($sformatf("rstdiv result c%0d", c), exe_result, 0);
        checkOutput($sformatf("rstdiv oprd2 c%0d", c), alu_oprd2, 0);
        checkOutput($sformatf("rstdiv divzero c%0d", c), exe_div_zero, 0);
      end else begin
        checkOutput($sformatf("rstdiv busy c%0d", c), busy, 0);
        checkOutput($sformatf("rstdiv valid c%0d", c), exe_valid, 0);
        if (c == 17) checkOutput("rstdiv ready c17", iss_ready, 1);
      end
    end
    run_div("udiv_after_rst", 1'b0, 32'd1000, 32'd3, 64'd333, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter DIV_CYCLES, 32, number of divider iteration cycles, one quotient bit per cycle.
REQ-002 Parameter XLEN, 64, exe_result width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 iss_valid  in  1  decode presents an instruction.
REQ-006 iss_ready  out  1  controller accepts this cycle; a transfer occurs when iss_valid && iss_ready at the clock edge.
REQ-007 iss_opcode / iss_op2 / iss_op3  in  2 / 3 / 6  instruction format fields.
REQ-008 iss_oprd2, iss_oprd3  in  32 each  source operands.
REQ-009 flush  in  1  abort the in-flight op (branch redirect).
REQ-010 mem_blocked  in  1  memory stage back-pressure.
REQ-011 alu_enable  out  1  one-cycle enable pulse to the ALU.
REQ-012 alu_opcode / alu_op2 / alu_op3 / alu_oprd2 / alu_oprd3  out  2 / 3 / 6 / 32 / 32  registered ALU fields.
REQ-013 alu_result  in  64 and alu_exe_mem  in  1  registered ALU outputs.
REQ-014 exe_valid  out  1, exe_result  out  XLEN, exe_div_zero  out  1  merged result to the memory stage.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, ISSUE, DIV, DONE.
REQ-017 iss_ready SHALL be 1 only in IDLE with mem_blocked=0 and flush=0.
REQ-018 Divide op: iss_opcode=2 and iss_op3[3:0] is 4'he (unsigned) or 4'hf (signed); all other accepted ops are ALU ops.
REQ-019 ALU op accepted at edge 0: alu_* fields registered, alu_enable=1 during cycle 1 only, state ISSUE during cycle 1, IDLE from cycle 2.
REQ-020 ALU path: exe_valid=alu_exe_mem and exe_result=alu_result; exe_valid is high in cycle 2 for an op accepted at edge 0; exe_div_zero=0.
REQ-021 Divide accepted at edge 0: state DIV during cycles 1..DIV_CYCLES, DONE during cycle DIV_CYCLES+1; exe_valid=1 for exactly that one cycle; IDLE afterwards; alu_enable stays 0.
REQ-022 Unsigned divide: 32-bit quotient, zero-extended to XLEN.
REQ-023 Signed divide: quotient truncates toward zero, sign-extended to XLEN; 0x80000000 / 0xFFFFFFFF SHALL return 0x80000000, sign-extended.
REQ-024 Divisor zero: no iteration; DONE in cycle 1; exe_result all ones; exe_div_zero=1.
REQ-025 mem_blocked=1 in DONE: state, exe_valid and exe_result hold until mem_blocked=0, then one further valid cycle and IDLE.
REQ-026 mem_blocked=1 in DIV: iteration continues.
REQ-027 flush=1 in ISSUE/DIV/DONE: return to IDLE at the next edge with no exe_valid for the aborted op; flush in IDLE has no effect.
REQ-028 Simultaneous flush and mem_blocked: flush wins.
REQ-029 Remainder is computed internally but not output.

Reset
REQ-030 While reset_n=0: state IDLE; every output 0, including iss_ready; exe_result=0; divider counter and registers cleared.
REQ-031 Reset mid-divide SHALL discard the op with no exe_valid after release.
REQ-032 iss_ready may rise in the first cycle after reset_n deasserts.

Structure
REQ-033 Shared package alu_pkg SHALL hold: the state enum; op3 codes OP3_UDIV=4'he and OP3_SDIV=4'hf; the default DIV_CYCLES.
REQ-034 The iterative restoring divider SHALL be a sub-module div_iter with interface start/dividend/divisor/signed -> done/quotient/remainder.

Verification
REQ-035 ALU add, oprd2=5, oprd3=7 accepted at edge 0 -> alu_enable in cycle 1 only; exe_valid in cycle 2; exe_result=12.
REQ-036 udiv 100/7 -> exe_valid in cycle 33 only; exe_result=14; busy cycles 1..33; iss_ready=0 throughout.
REQ-037 sdiv -100/7 -> exe_result=64'hFFFF_FFFF_FFFF_FFF2; sdiv of divisor 0 -> cycle 1 exe_valid, exe_div_zero=1, result all ones.
REQ-038 udiv with mem_blocked high in cycles 20..40 -> quotient ready in DONE; exe_valid held high through cycle 41; IDLE in cycle 42.
REQ-039 flush in cycle 10 of a divide -> IDLE in cycle 11 with no exe_valid; next ALU op accepted normally.
REQ-040 reset_n low in cycle 15 of a divide -> all outputs 0 immediately; no exe_valid after release; iss_ready=1 in the first cycle after release.
